// File: rtl/data_register.sv
// Edge-triggered WIDTH-bit storage register for the SUBNEG datapath.
// Captures every rising edge; asynchronous active-high reset to RESET_VALUE.
module data_register #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= RESET_VALUE;
      end else begin
         data_q <= data_d;
      end
   end

   // Pure flop output: no path from in to out between edges.
   assign out = data_q;

endmodule

// File: tb/tb_data_register.sv
// Directed plus randomized bench for data_register at 8-bit default
// and at WIDTH=16 / RESET_VALUE=16'hBEEF.
module tb_data_register;

   logic        clk;
   logic        reset;
   logic [7:0]  in8;
   logic [7:0]  out8;
   logic [15:0] in16;
   logic [15:0] out16;

   int compared;
   int mismatched;

   logic [7:0]  exp8;
   logic [15:0] exp16;
   logic [31:0] r;

   data_register u_dut8 (
      .clk   (clk),
      .reset (reset),
      .in    (in8),
      .out   (out8)
   );

   data_register #(
      .WIDTH       (16),
      .RESET_VALUE (16'hBEEF)
   ) u_dut16 (
      .clk   (clk),
      .reset (reset),
      .in    (in16),
      .out   (out16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h at t=%0t",
                tag, obs, exp, $time);
      end
   endtask

   task automatic check_both(input string tag);
      check({tag, "_w8"}, {8'h00, out8}, {8'h00, exp8});
      check({tag, "_w16"}, out16, exp16);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;

      // Reset held from t=0; edge at 5 must not matter.
      reset = 1'b1;
      in8   = 8'h00;
      in16  = 16'h0000;
      exp8  = 8'h00;
      exp16 = 16'hBEEF;
      #10;
      check_both("reset");

      // Load at edge 15.
      reset = 1'b0;
      in8   = 8'hAA;
      in16  = 16'h1234;
      #3;
      check_both("before_first_edge");
      #7;
      exp8  = 8'hAA;
      exp16 = 16'h1234;
      check_both("load");

      // Overwrite at edge 25.
      in8  = 8'h55;
      in16 = 16'h8001;
      #10;
      exp8  = 8'h55;
      exp16 = 16'h8001;
      check_both("overwrite");

      // Hold: same input recaptured at edge 35.
      #10;
      check_both("hold");

      // Async reset at t=42, between edges.
      #2;
      reset = 1'b1;
      in8   = 8'hFF;
      in16  = 16'hFFFF;
      #1;
      exp8  = 8'h00;
      exp16 = 16'hBEEF;
      check_both("async_reset");
      #3;
      check_both("reset_over_edge45");
      #10;
      check_both("reset_over_edge55");

      // Release at t=60; first capture at edge 65.
      #4;
      reset = 1'b0;
      in8   = 8'h3C;
      in16  = 16'hCAFE;
      #3;
      check_both("release_no_load");
      #4;
      exp8  = 8'h3C;
      exp16 = 16'hCAFE;
      check_both("release_capture");

      // Randomized: t is 2ns after an edge at loop start.
      for (int i = 0; i < 200; i++) begin
         r    = $urandom;
         in8  = r[7:0];
         in16 = r[23:8];
         #5;
         check_both("rand_hold");
         // Glitch the input late in the cycle; last value wins.
         r = $urandom;
         if (r[0]) begin
            r    = $urandom;
            in8  = r[7:0];
            in16 = r[23:8];
         end
         r = $urandom;
         if (r[2:0] == 3'd0) begin
            reset = 1'b1;
            exp8  = 8'h00;
            exp16 = 16'hBEEF;
            #1;
            check_both("rand_async_reset");
            reset = 1'b0;
            #4;
         end else begin
            #5;
         end
         exp8  = in8;
         exp16 = in16;
         check_both("rand_capture");
      end

      // Unknown input propagates unmasked.
      #3;
      in8  = 8'hxx;
      in16 = 16'h0F0F;
      #10;
      exp8  = 8'hxx;
      exp16 = 16'h0F0F;
      check_both("x_propagation");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
